// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style INTA bus sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK1  = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_ACK2  = 3'd3,
        ST_WAIT3 = 3'd4,
        ST_ACK3  = 3'd5
    } seq_state_e;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    localparam logic [2:0] SPURIOUS_IR = 3'd7;

    function automatic logic [7:0] vec_8086(input logic [4:0] base_hi, input logic [2:0] id);
        return {base_hi, id};
    endfunction

    function automatic logic [7:0] call_lo_8080(input logic [2:0] a7_a5, input logic [2:0] id);
        return {a7_a5, id, 2'b00};
    endfunction

endpackage

// File: rtl/inta_edge_det.sv
// INTA strobe edge detector; pulses are decoded from the registered inta_n history.
module inta_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic inta_n_q, inta_n_d;
    logic armed_q, armed_d;

    always_comb begin
        inta_n_d = inta_n;
        armed_d  = 1'b1;
    end

    // The first edge after reset only loads history, so a strobe already low is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_n_q <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            inta_n_q <= inta_n_d;
            armed_q  <= armed_d;
        end
    end

    assign fall = armed_q &  inta_n_q & ~inta_n;
    assign rise = armed_q & ~inta_n_q &  inta_n;

endmodule

// File: rtl/inta_bus_sequencer.sv
// INTA bus sequencer: emits 8080 CALL / 8086 vector bytes across INTA pulses.
// Optional WAIT2/WAIT3 watchdog enabled by defining INTA_TIMEOUT_EN.
module inta_bus_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] irq_id,
    input  logic [7:0] vec_base,
    input  logic [2:0] addr_lo,
    input  logic [7:0] addr_hi,
    input  logic       mode_8086,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       isr_set,
    output logic [2:0] isr_id,
    output logic       busy,
    output logic       seq_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    logic fall, rise, wd_expire;
    logic unused_vec_lo;

    assign unused_vec_lo = ^vec_base[2:0];

    inta_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    seq_state_e state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [2:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       mode_q, mode_d;
    logic [2:0] isr_id_q, isr_id_d;
    logic       isr_set_q, isr_set_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        mode_d    = mode_q;
        isr_id_d  = isr_id_q;
        isr_set_d = 1'b0;
        unique case (state_q)
            ST_IDLE: if (fall) begin
                state_d   = ST_ACK1;
                isr_id_d  = int_req ? irq_id : SPURIOUS_IR;
                isr_set_d = int_req;
                vec_d     = vec_base[7:3];
                lo_d      = addr_lo;
                hi_d      = addr_hi;
                mode_d    = mode_8086;
            end
            ST_ACK1:  if (rise) state_d = ST_WAIT2;
            ST_WAIT2: if (fall) state_d = ST_ACK2;
                      else if (wd_expire) state_d = ST_IDLE;
            ST_ACK2:  if (rise) state_d = mode_q ? ST_IDLE : ST_WAIT3;
            ST_WAIT3: if (fall) state_d = ST_ACK3;
                      else if (wd_expire) state_d = ST_IDLE;
            ST_ACK3:  if (rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus byte is decoded from the next state so it registers on the detecting edge.
    always_comb begin
        d_out_d = '0;
        d_oe_d  = 1'b0;
        unique case (state_d)
            ST_ACK1: begin
                d_oe_d  = ~mode_d;
                d_out_d = mode_d ? 8'h00 : CALL_OPCODE;
            end
            ST_ACK2: begin
                d_oe_d  = 1'b1;
                d_out_d = mode_d ? vec_8086(vec_d, isr_id_d) : call_lo_8080(lo_d, isr_id_d);
            end
            ST_ACK3: begin
                d_oe_d  = 1'b1;
                d_out_d = hi_d;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            mode_q    <= 1'b0;
            isr_id_q  <= '0;
            isr_set_q <= 1'b0;
            d_out_q   <= '0;
            d_oe_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            mode_q    <= mode_d;
            isr_id_q  <= isr_id_d;
            isr_set_q <= isr_set_d;
            d_out_q   <= d_out_d;
            d_oe_q    <= d_oe_d;
            busy_q    <= busy_d;
        end
    end

`ifdef INTA_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_err_q, seq_err_d;
    logic             in_wait;

    assign in_wait   = (state_q == ST_WAIT2) || (state_q == ST_WAIT3);
    assign wd_expire = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every WAIT entry; the abort edge is the TIMEOUT_CYCLES-th in WAIT.
    always_comb begin
        cnt_d     = (in_wait && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
        seq_err_d = wd_expire && !fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign wd_expire = 1'b0;
    assign seq_err   = 1'b0;
`endif

    assign d_out   = d_out_q;
    assign d_oe    = d_oe_q;
    assign isr_set = isr_set_q;
    assign isr_id  = isr_id_q;
    assign busy    = busy_q;

endmodule
